// File: rtl/float_div_seq_pkg.sv
// float_pack: shared float format, divider constants and divider FSM states
package float_pack;

    localparam int Nm = 23;
    localparam int Ne = 8;
    localparam int BIAS = 2 ** (Ne - 1) - 1;
    localparam int EXP_MAX = 2 ** Ne - 1;

    typedef struct packed {
        logic          s;
        logic [Ne-1:0] e;
        logic [Nm-1:0] m;
    } float;

    typedef enum logic [1:0] {IDLE, DIV, NORM} div_state_t;

endpackage

// File: rtl/float_div_seq.sv
// float_div_seq: restoring float divider, one quotient bit per clock.
// Ports: clk_i/rst_i (sync, active-high); start_i, op_a_i, op_b_i request a
// divide op_a_i/op_b_i; busy_o while running; done_o one-cycle pulse with
// result_o and dz_o (divide-by-zero), both held until the next result.
module float_div_seq
    import float_pack::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    input  float op_a_i,
    input  float op_b_i,
    output logic busy_o,
    output logic done_o,
    output float result_o,
    output logic dz_o
);

    localparam int CW = $clog2(Nm + 2);
    localparam logic signed [Ne+1:0] BIAS_S = (Ne + 2)'(BIAS);
    localparam logic signed [Ne+1:0] EMAX_S = (Ne + 2)'(EXP_MAX);
    localparam logic signed [Ne+1:0] ONE_S = (Ne + 2)'(1);

    div_state_t state_q;
    logic [CW-1:0] cnt_q;
    logic [Nm+1:0] rem_q, q_q;
    logic [Nm:0] div_q;
    logic s_q, za_q, zb_q;
    logic signed [Ne+1:0] exp_q;

    logic ge_d, a_zero_d, b_zero_d;
    logic [Nm+1:0] sub_d, rem_d;
    logic signed [Ne+1:0] exp_in_d, exp_d;
    logic [Nm-1:0] mant_d;
    float norm_d;

    always_comb begin
        a_zero_d = op_a_i.e == '0;
        b_zero_d = op_b_i.e == '0;
        exp_in_d = $signed({2'b00, op_a_i.e}) - $signed({2'b00, op_b_i.e}) + BIAS_S;
        ge_d = rem_q >= {1'b0, div_q};
        sub_d = ge_d ? rem_q - {1'b0, div_q} : rem_q;
        // rem < div after the subtract, so the shift never loses a set bit
        rem_d = sub_d << 1;
        exp_d = q_q[Nm+1] ? exp_q : exp_q - ONE_S;
        mant_d = q_q[Nm+1] ? q_q[Nm:1] : q_q[Nm-1:0];
        norm_d = zb_q || exp_d >= EMAX_S ? {s_q, {Ne{1'b1}}, {Nm{1'b0}}} :
                 za_q || exp_d[Ne+1] || exp_d == '0 ? {s_q, {Ne{1'b0}}, {Nm{1'b0}}} :
                 {s_q, exp_d[Ne-1:0], mant_d};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            busy_o <= 1'b0;
            done_o <= 1'b0;
            result_o <= '0;
            dz_o <= 1'b0;
            cnt_q <= '0;
            rem_q <= '0;
            q_q <= '0;
            div_q <= '0;
            s_q <= 1'b0;
            za_q <= 1'b0;
            zb_q <= 1'b0;
            exp_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_o <= 1'b0;
                    // the done cycle still belongs to the finishing operation
                    if (start_i && !done_o) begin
                        busy_o <= 1'b1;
                        s_q <= op_a_i.s ^ op_b_i.s;
                        za_q <= a_zero_d;
                        zb_q <= b_zero_d;
                        exp_q <= exp_in_d;
                        rem_q <= {1'b0, 1'b1, op_a_i.m};
                        div_q <= {1'b1, op_b_i.m};
                        q_q <= '0;
                        cnt_q <= CW'(Nm + 1);
                        state_q <= a_zero_d || b_zero_d ? NORM : DIV;
                    end
                end
                DIV: begin
                    q_q[cnt_q] <= ge_d;
                    rem_q <= rem_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) state_q <= NORM;
                end
                NORM: begin
                    result_o <= norm_d;
                    dz_o <= zb_q;
                    done_o <= 1'b1;
                    busy_o <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_float_div_seq.sv
// tb_float_div_seq: scoreboard bench for float_div_seq with directed vectors
module tb_float_div_seq;
    import float_pack::*;

    logic clk = 1'b0;
    logic rst_i = 1'b1;
    logic start_i = 1'b0;
    float op_a_i = '0;
    float op_b_i = '0;
    logic busy_o, done_o, dz_o;
    float result_o;

    float_div_seq dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .op_a_i(op_a_i), .op_b_i(op_b_i),
        .busy_o(busy_o), .done_o(done_o), .result_o(result_o), .dz_o(dz_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] r;
        logic dz;
        int lat;
        int t0;
    } exp_t;

    exp_t sb[$];
    int cyc = 0;
    int errs = 0;
    int checks = 0;
    logic chk_next = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", nm, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (chk_next) chk("done_pulse", {31'b0, done_o}, 32'd0);
        chk_next = 1'b0;
        if (!rst_i && done_o) begin
            chk_next = 1'b1;
            if (sb.size() == 0) begin
                checks++;
                errs++;
                $display("FAIL unexpected_done got=%h", result_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", result_o, e.r);
                chk("dz", {31'b0, dz_o}, {31'b0, e.dz});
                chk("latency", cyc - e.t0, e.lat);
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r,
                         input logic dz, input int lat);
        int n = 0;
        exp_t e;
        @(negedge clk);
        while ((busy_o || done_o) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("idle_timeout", 32'd1, 32'd0);
        op_a_i = a;
        op_b_i = b;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        e.r = r;
        e.dz = dz;
        e.lat = lat;
        e.t0 = cyc;
        sb.push_back(e);
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || busy_o) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("drain_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        chk("rst_busy", {31'b0, busy_o}, 32'd0);
        chk("rst_done", {31'b0, done_o}, 32'd0);
        chk("rst_result", result_o, 32'd0);
        chk("rst_dz", {31'b0, dz_o}, 32'd0);

        issue(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 26);
        issue(32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0, 26);
        issue(32'hC0C00000, 32'h40000000, 32'hC0400000, 1'b0, 26);
        issue(32'h40A00000, 32'h00000000, 32'h7F800000, 1'b1, 1);
        issue(32'h00000000, 32'h40A00000, 32'h00000000, 1'b0, 1);
        issue(32'h00000000, 32'h00000000, 32'h7F800000, 1'b1, 1);
        issue(32'h80000000, 32'h40A00000, 32'h80000000, 1'b0, 1);
        issue(32'h0D800000, 32'h71800000, 32'h00000000, 1'b0, 26);
        issue(32'h71800000, 32'h0D800000, 32'h7F800000, 1'b0, 26);
        issue(32'h40400000, 32'h40000000, 32'h3FC00000, 1'b0, 26);
        issue(32'h3FC00000, 32'h40400000, 32'h3F000000, 1'b0, 26);
        drain();

        issue(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 26);
        repeat (8) @(negedge clk);
        op_a_i = 32'h3F800000;
        op_b_i = 32'h40400000;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        n = 0;
        while (!done_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("done_timeout", 32'd1, 32'd0);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        chk("start_in_done_ignored", {31'b0, busy_o}, 32'd0);
        drain();

        issue(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 26);
        repeat (11) @(negedge clk);
        rst_i = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("abort_busy", {31'b0, busy_o}, 32'd0);
        chk("abort_done", {31'b0, done_o}, 32'd0);
        chk("abort_result", result_o, 32'd0);
        chk("abort_dz", {31'b0, dz_o}, 32'd0);
        rst_i = 1'b0;
        repeat (40) @(negedge clk);
        issue(32'h40400000, 32'h40000000, 32'h3FC00000, 1'b0, 26);
        drain();
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
